fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage; sits directly upstream of the memory's instruction port.
//   Owns the 8-bit PC and drives imem_addr; the memory returns the byte combinationally.
//   Loads the start PC from a reset vector and assembles 1- or 2-byte instructions.
//   Drives the IF/ID pipeline register consumed by decode; obeys stall and branch redirect.
// PARAMETERS
//   RESET_VEC_ADDR  8'h00  address whose byte is loaded into PC after reset
//   IMM_OPC         4'hC   opcode[7:4] value marking a 2-byte instruction (opcode + immediate)
// PORTS
//   clk            in   1  rising-edge clock
//   rst            in   1  asynchronous reset, active-high
//   imem_addr      out  8  instruction-port address to memory
//   imem_data      in   8  instruction byte at imem_addr (combinational, same cycle)
//   stall          in   1  hold PC, FSM and IF/ID register
//   branch_taken   in   1  redirect PC to branch_target and squash in-flight fetch
//   branch_target  in   8  redirect address
//   if_valid       out  1  IF/ID register holds a valid instruction
//   if_instr       out  8  opcode byte
//   if_imm         out  8  immediate byte (2-byte instructions only, else 8'h00)
//   if_pc_next     out  8  address following the last byte of this instruction
// BEHAVIOUR
//   Reset (rst=1, async): PC=8'h00, state=S_VEC, hold=8'h00.
//     Outputs: if_valid=0, if_instr=8'h00, if_imm=8'h00, if_pc_next=8'h00.
//   imem_addr is combinational: RESET_VEC_ADDR in S_VEC, otherwise PC.
//   States:
//     S_VEC    1 cycle after rst release: PC<=imem_data; ->S_FETCH; if_valid<=0.
//              stall and branch_taken are ignored in this state.
//     S_FETCH  2-byte opcode (imem_data[7:4]==IMM_OPC): hold<=imem_data; PC<=PC+1; ->S_IMM;
//              if_valid<=0.
//              otherwise: if_instr<=imem_data; if_imm<=0; if_pc_next<=PC+1; if_valid<=1;
//              PC<=PC+1.
//     S_IMM    if_instr<=hold; if_imm<=imem_data; if_pc_next<=PC+1; if_valid<=1; PC<=PC+1;
//              ->S_FETCH.
//   Priority (S_FETCH/S_IMM): branch_taken > stall > normal.
//     branch_taken: PC<=branch_target; if_valid<=0; ->S_FETCH; any held opcode is discarded.
//     stall (without branch): PC, state, hold and all if_* registers are unchanged.
//   Latency: a 1-byte instr is valid 1 cycle after its address is presented.
//     A 2-byte instr is valid 2 cycles after its opcode address is presented.
//   Throughput: 1 instr/cycle for 1-byte instrs; bubble (if_valid=0) while fetching an opcode
//     byte of a 2-byte instr.
//   Arithmetic: PC+1 is modulo 256; 8'hFF wraps to 8'h00, and an immediate at 8'h00 is legal.
//   Memory written at addr==PC in the same cycle: fetch uses the pre-write byte (read is
//     combinational, write lands at the edge).
//   Reset mid-operation (any state): immediate return to reset values; a partial 2-byte
//     fetch is lost.
// TESTING
//   1 mem[00]=8'h10, mem[10]=8'h01, mem[11]=8'h02; release rst -> imem_addr=00, then PC=10;
//     if_instr=01 (pc_next=11), then 02 (pc_next=12) on consecutive cycles.
//   2 mem[10]=8'hC3, mem[11]=8'h5A -> one bubble; then if_valid=1, if_instr=C3, if_imm=5A,
//     if_pc_next=12.
//   3 Assert stall 3 cycles mid-stream -> imem_addr and all if_* frozen; resumes with no
//     skipped or duplicated instruction.
//   4 branch_taken=1, target=8'h40 in S_IMM, stall=1 same cycle -> next if_valid=0;
//     imem_addr=40; held C3 never emitted.
//   5 PC=8'hFF holding 8'hC0, mem[00]=8'h77 -> if_instr=C0, if_imm=77, if_pc_next=01.
//   6 Assert rst for 1 cycle while in S_IMM -> all outputs 0 immediately (async); S_VEC
//     reloads PC from mem[RESET_VEC_ADDR].

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, stall/redirect controls
// from downstream, and the IF/ID register outputs consumed by decode.
//   imem_addr/imem_data : combinational instruction-memory read port
//   stall, branch_*     : hold / redirect requests from later stages
//   if_*                : IF/ID pipeline register contents
// master = fetch unit, slave = memory plus pipeline environment.
interface fetch_if;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       if_valid;
  logic [7:0] if_instr;
  logic [7:0] if_imm;
  logic [7:0] if_pc_next;

  modport master (
    output imem_addr, if_valid, if_instr, if_imm, if_pc_next,
    input  imem_data, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_imm, if_pc_next,
    output imem_data, stall, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the 8-bit PC, loads the start PC from the
// byte stored at RESET_VEC_ADDR, and assembles 1-byte instructions or
// 2-byte (opcode + immediate) instructions into the IF/ID register.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : fetch_if.master (imem port, stall/branch inputs, if_* outputs)
module fetch_unit #(
  parameter logic [7:0] RESET_VEC_ADDR = 8'h00,
  parameter logic [3:0] IMM_OPC        = 4'hC
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {S_VEC, S_FETCH, S_IMM} state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] instr;
    logic [7:0] imm;
    logic [7:0] pc_next;
  } ifid_t;

  state_t     state, state_n;
  logic [7:0] pc, pc_n;
  logic [7:0] hold, hold_n;
  ifid_t      ifid, ifid_n;
  logic [7:0] pc_inc;

  // Memory reads the vector location first, then follows the PC.
  assign bus.imem_addr  = (state == S_VEC) ? RESET_VEC_ADDR : pc;
  assign pc_inc         = pc + 8'd1;  // 8-bit, wraps FF -> 00

  assign bus.if_valid   = ifid.valid;
  assign bus.if_instr   = ifid.instr;
  assign bus.if_imm     = ifid.imm;
  assign bus.if_pc_next = ifid.pc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_VEC;
      pc    <= 8'h00;
      hold  <= 8'h00;
      ifid  <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      hold  <= hold_n;
      ifid  <= ifid_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    hold_n  = hold;
    ifid_n  = ifid;
    case (state)
      // Vector load: stall and redirect are not honoured yet.
      S_VEC: begin
        pc_n         = bus.imem_data;
        ifid_n.valid = 1'b0;
        state_n      = S_FETCH;
      end
      S_FETCH: begin
        if (bus.branch_taken) begin
          pc_n         = bus.branch_target;
          ifid_n.valid = 1'b0;
        end else if (!bus.stall) begin
          pc_n = pc_inc;
          if (bus.imem_data[7:4] == IMM_OPC) begin
            // Opcode of a 2-byte instruction: park it, emit a bubble.
            hold_n       = bus.imem_data;
            ifid_n.valid = 1'b0;
            state_n      = S_IMM;
          end else begin
            ifid_n.valid   = 1'b1;
            ifid_n.instr   = bus.imem_data;
            ifid_n.imm     = 8'h00;
            ifid_n.pc_next = pc_inc;
          end
        end
      end
      S_IMM: begin
        if (bus.branch_taken) begin
          // Redirect drops the parked opcode; it is never emitted.
          pc_n         = bus.branch_target;
          ifid_n.valid = 1'b0;
          state_n      = S_FETCH;
        end else if (!bus.stall) begin
          ifid_n.valid   = 1'b1;
          ifid_n.instr   = hold;
          ifid_n.imm     = bus.imem_data;
          ifid_n.pc_next = pc_inc;
          pc_n           = pc_inc;
          state_n        = S_FETCH;
        end
      end
      default: begin
        state_n = S_VEC;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic clk;
  logic rst;
  logic [7:0] mem [256];
  int errors = 0;
  int checks = 0;

  fetch_if bus();
  assign bus.imem_data = mem[bus.imem_addr];

  fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic       br;
    logic [7:0] tgt;
    logic       e_valid;
    logic [7:0] e_instr;
    logic [7:0] e_imm;
    logic [7:0] e_pcn;
    logic [7:0] e_addr;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [7:0] i,
                           input logic [7:0] imm, input logic [7:0] pn, input logic [7:0] a);
    check({tag, ".valid"}, {7'b0, bus.if_valid}, {7'b0, v});
    check({tag, ".instr"}, bus.if_instr, i);
    check({tag, ".imm"}, bus.if_imm, imm);
    check({tag, ".pc_next"}, bus.if_pc_next, pn);
    check({tag, ".addr"}, bus.imem_addr, a);
  endtask

  // Reference model state: started = vector already loaded; pend = parked opcode or -1.
  bit         m_started;
  logic [7:0] m_pc, m_i, m_imm, m_pn;
  logic       m_v;
  int         m_pend;

  task automatic model_reset();
    m_started = 0; m_pc = 0; m_i = 0; m_imm = 0; m_pn = 0; m_v = 0; m_pend = -1;
  endtask

  function automatic logic [7:0] model_addr();
    return m_started ? m_pc : 8'h00;
  endfunction

  // One clock of instruction-stream semantics, given the inputs of that cycle.
  task automatic model_step(input logic st, input logic br, input logic [7:0] tgt);
    logic [7:0] b;
    b = mem[model_addr()];
    if (!m_started) begin
      m_pc = b; m_started = 1; m_v = 0;
    end else if (br) begin
      m_pc = tgt; m_pend = -1; m_v = 0;
    end else if (st) begin
    end else if (m_pend >= 0) begin
      m_i = 8'(m_pend); m_imm = b; m_pn = 8'((m_pc + 1) % 256); m_v = 1;
      m_pc = m_pn; m_pend = -1;
    end else if (b[7:4] == 4'hC) begin
      m_pend = int'(b); m_pc = 8'((m_pc + 1) % 256); m_v = 0;
    end else begin
      m_i = b; m_imm = 0; m_pn = 8'((m_pc + 1) % 256); m_v = 1; m_pc = m_pn;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10; mem[8'h10] = 8'h01; mem[8'h11] = 8'h02; mem[8'h12] = 8'hC3;
    mem[8'h13] = 8'h5A; mem[8'h14] = 8'h04; mem[8'h15] = 8'hC5; mem[8'h16] = 8'h66;
    mem[8'h40] = 8'h09; mem[8'h41] = 8'hC1; mem[8'h42] = 8'h7E; mem[8'h43] = 8'h00;
    mem[8'hFF] = 8'hC0; mem[8'h01] = 8'h22; mem[8'h02] = 8'hC8; mem[8'h03] = 8'h33;

    //           stall br  tgt    v   instr  imm    pc_nx  addr
    tbl[0]  = '{1, 1, 8'h55, 0, 8'h00, 8'h00, 8'h00, 8'h10}; // vector ignores stall/branch
    tbl[1]  = '{0, 0, 8'h00, 1, 8'h01, 8'h00, 8'h11, 8'h11};
    tbl[2]  = '{0, 0, 8'h00, 1, 8'h02, 8'h00, 8'h12, 8'h12};
    tbl[3]  = '{1, 0, 8'h00, 1, 8'h02, 8'h00, 8'h12, 8'h12}; // 3-cycle stall
    tbl[4]  = '{1, 0, 8'h00, 1, 8'h02, 8'h00, 8'h12, 8'h12};
    tbl[5]  = '{1, 0, 8'h00, 1, 8'h02, 8'h00, 8'h12, 8'h12};
    tbl[6]  = '{0, 0, 8'h00, 0, 8'h02, 8'h00, 8'h12, 8'h13}; // C3 opcode bubble
    tbl[7]  = '{0, 0, 8'h00, 1, 8'hC3, 8'h5A, 8'h14, 8'h14};
    tbl[8]  = '{0, 0, 8'h00, 1, 8'h04, 8'h00, 8'h15, 8'h15};
    tbl[9]  = '{0, 0, 8'h00, 0, 8'h04, 8'h00, 8'h15, 8'h16}; // C5 parked
    tbl[10] = '{1, 1, 8'h40, 0, 8'h04, 8'h00, 8'h15, 8'h40}; // branch beats stall in S_IMM
    tbl[11] = '{0, 0, 8'h00, 1, 8'h09, 8'h00, 8'h41, 8'h41};
    tbl[12] = '{1, 0, 8'h00, 1, 8'h09, 8'h00, 8'h41, 8'h41}; // stall on 2-byte opcode
    tbl[13] = '{0, 0, 8'h00, 0, 8'h09, 8'h00, 8'h41, 8'h42};
    tbl[14] = '{1, 0, 8'h00, 0, 8'h09, 8'h00, 8'h41, 8'h42}; // stall in S_IMM
    tbl[15] = '{0, 0, 8'h00, 1, 8'hC1, 8'h7E, 8'h43, 8'h43};
    tbl[16] = '{0, 1, 8'hFF, 0, 8'hC1, 8'h7E, 8'h43, 8'hFF}; // branch in S_FETCH
    tbl[17] = '{0, 0, 8'h00, 0, 8'hC1, 8'h7E, 8'h43, 8'h00}; // PC wraps FF->00
    tbl[18] = '{0, 0, 8'h00, 1, 8'hC0, 8'h10, 8'h01, 8'h01}; // immediate at 00
    tbl[19] = '{0, 0, 8'h00, 1, 8'h22, 8'h00, 8'h02, 8'h02};

    repeat (2) @(negedge clk);
    check_all("reset", 0, 8'h00, 8'h00, 8'h00, 8'h00);
    rst = 1'b0;

    for (int k = 0; k < 20; k++) begin
      bus.stall = tbl[k].stall; bus.branch_taken = tbl[k].br; bus.branch_target = tbl[k].tgt;
      @(negedge clk);
      check_all($sformatf("tbl%0d", k), tbl[k].e_valid, tbl[k].e_instr, tbl[k].e_imm,
                tbl[k].e_pcn, tbl[k].e_addr);
    end
    bus.stall = 0; bus.branch_taken = 0;

    // Enter S_IMM on C8, then async reset mid-instruction.
    @(negedge clk);
    check_all("c8_bubble", 0, 8'h22, 8'h00, 8'h02, 8'h03);
    mem[8'h00] = 8'h77; mem[8'h77] = 8'h01; mem[8'h78] = 8'h05;
    #2 rst = 1'b1;
    #1 check_all("async_rst", 0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all("reload", 0, 8'h00, 8'h00, 8'h00, 8'h77);

    // Write lands at the same edge that fetches addr 77: pre-write byte is used.
    @(posedge clk);
    mem[8'h77] <= 8'hC9;
    @(negedge clk);
    check_all("wr_same", 1, 8'h01, 8'h00, 8'h78, 8'h78);
    @(negedge clk);
    check_all("wr_next", 1, 8'h05, 8'h00, 8'h79, 8'h79);

    // Randomised run against the reference model.
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) mem[i][7:4] = 4'hC;
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      logic st, br;
      logic [7:0] tg;
      st = ($urandom_range(0, 4) == 0);
      br = ($urandom_range(0, 9) == 0);
      tg = 8'($urandom);
      bus.stall = st; bus.branch_taken = br; bus.branch_target = tg;
      model_step(st, br, tg);
      @(negedge clk);
      check_all($sformatf("rnd%0d", n), m_v, m_i, m_imm, m_pn, model_addr());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
